// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit timing.
// The receiver and transmitter both import this package.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 347;  // 40 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // Even parity bit: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pad inputs.
// RST_VAL sets the value both flops take in reset (1 for idle-high lines).
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg[gi] <= RST_VAL;
          sync_reg[gi] <= RST_VAL;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output, framing and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err_o output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   frame_err_o,
  output logic                   overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err_o,
`endif
  output logic                   busy_o
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);

  logic                   rx_s;
  uart_state_e            state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [2:0]             bit_idx_reg;
  logic [UART_DATA_W-1:0] shift_reg;
  logic                   busy_reg;
  logic                   frame_err_reg;
  logic [UART_DATA_W-1:0] data_reg;
  logic                   valid_reg;
  logic                   overrun_reg;
  logic                   stop_sample;
  logic                   byte_ok;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_reg;
  logic                   parity_err_reg;
`endif

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .d  (rx_i),
    .q  (rx_s)
  );

  // Byte completes in the cycle the stop bit is sampled high.
  assign stop_sample = (state_reg == STOP) && (cnt_reg == BIT_CNT);
`ifdef UART_RX_PARITY_EN
  assign byte_ok = stop_sample && rx_s && !par_bad_reg;
`else
  assign byte_ok = stop_sample && rx_s;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      busy_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rx_s) begin
            state_reg <= START;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == HALF_CNT) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              bit_idx_reg <= '0;
              state_reg   <= DATA;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_CNT) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s, shift_reg[UART_DATA_W-1:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == BIT_CNT) begin
            cnt_reg     <= '0;
            par_bad_reg <= (rx_s != even_parity(shift_reg));
            state_reg   <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_reg == BIT_CNT) begin
            cnt_reg <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= par_bad_reg;
`endif
            if (rx_s) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        BREAK: begin
          // A line held low must go high before a new start bit is accepted.
          cnt_reg <= '0;
          if (rx_s) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register: a new byte may replace one accepted in the same cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (byte_ok) begin
        if (!valid_reg || ready_i) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_o      = data_reg;
  assign valid_o     = valid_reg;
  assign overrun_o   = overrun_reg;
  assign frame_err_o = frame_err_reg;
  assign busy_o      = busy_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_reg;
`endif

endmodule
